bram_sp_arbiter: RTL and testbench

//  Two-client arbiter in front of one bram_sync_sp instance; shares its single port between client A and B.
//  Per-cycle request/ack handshake, round-robin fairness, optional locked bursts capped by MAX_BURST.

---
 rtl/bram_sp_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bram_sp_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sp_arbiter.sv
// -----------------------------------------------------------------------------
// bram_sp_arbiter
//   Shares the single port of one bram_sync_sp instance between two clients,
//   A and B. Each cycle at most one client is acknowledged. The acknowledged
//   client's address, write data and write strobe go straight to the BRAM.
//
//   Arbitration:
//   - With no lock held, a single requester wins. A tie goes to the client that
//     was not granted most recently (round-robin).
//   - A client that asserts lock with its granted access keeps the grant on
//     following cycles. The lock ends when the client stops requesting, drops
//     lock, or is forced to yield after MAX_BURST-1 locked grants while the
//     other client is waiting.
//
//   Read data from the BRAM arrives one cycle after the read is acknowledged.
//   It is routed to the client that issued the read. The other client's rdata
//   stays at zero.
//
//   Build option:
//     ARB_FIXED_PRIO_EN : A always wins ties when no lock is held. Locks and the
//                         MAX_BURST cap still apply.
//
// Ports
//   clk                      clock, all logic on posedge
//   rst                      asynchronous active-low reset
//   a_req/a_wr/a_lock        client A request, write select, keep-grant request
//   a_addr/a_wdata           client A address and write data
//   a_ack                    client A accepted this cycle (combinational)
//   a_rvalid/a_rdata         client A read return, one cycle after the read ack
//   b_*                      same set for client B
//   ram_wr/ram_addr/ram_din  BRAM port controls
//   ram_dout                 BRAM registered read data
// -----------------------------------------------------------------------------
module bram_sp_arbiter #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 4,
  parameter int MAX_BURST      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_req,
  input  logic                      a_wr,
  input  logic                      a_lock,
  input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [RAM_DATA_WIDTH-1:0] a_wdata,
  output logic                      a_ack,
  output logic                      a_rvalid,
  output logic [RAM_DATA_WIDTH-1:0] a_rdata,
  input  logic                      b_req,
  input  logic                      b_wr,
  input  logic                      b_lock,
  input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [RAM_DATA_WIDTH-1:0] b_wdata,
  output logic                      b_ack,
  output logic                      b_rvalid,
  output logic [RAM_DATA_WIDTH-1:0] b_rdata,
  output logic                      ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_din,
  input  logic [RAM_DATA_WIDTH-1:0] ram_dout
);

  localparam int CW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t                    state_q, state_d;
  logic                      rr_last_q, rr_last_d;   // 0: A granted last, 1: B
  logic [CW-1:0]             burst_q, burst_d;
  logic                      cap;
  logic                      gnt_a, gnt_b;
  logic [RAM_ADDR_WIDTH-1:0] hold_addr_q;
  logic [RAM_DATA_WIDTH-1:0] hold_din_q;
  logic                      vld_p1, own_b_p1;

  // burst_q saturates at the cap, so a lock that outlasts a quiet period
  // still yields as soon as the other client shows up.
  assign cap = (burst_q >= CW'(MAX_BURST - 1));

  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    state_d   = IDLE;
    burst_d   = '0;
    rr_last_d = rr_last_q;
    // Nothing is granted while reset is held, so the BRAM sees no write.
    if (rst) begin
      case (state_q)
        LOCK_A: begin
          if (a_req) begin
            if (b_req && cap) gnt_b = 1'b1;
            else              gnt_a = 1'b1;
          end else begin
            gnt_b = b_req;
          end
        end
        LOCK_B: begin
          if (b_req) begin
            if (a_req && cap) gnt_a = 1'b1;
            else              gnt_b = 1'b1;
          end else begin
            gnt_a = a_req;
          end
        end
        default: begin
          if (a_req && b_req) begin
`ifdef ARB_FIXED_PRIO_EN
            gnt_a = 1'b1;
`else
            if (rr_last_q) gnt_a = 1'b1;
            else           gnt_b = 1'b1;
`endif
          end else begin
            gnt_a = a_req;
            gnt_b = b_req;
          end
        end
      endcase
    end
    if (gnt_a) begin
      rr_last_d = 1'b0;
      if (a_lock) begin
        state_d = LOCK_A;
        burst_d = (state_q != LOCK_A) ? CW'(1) : (cap ? burst_q : burst_q + 1'b1);
      end
    end else if (gnt_b) begin
      rr_last_d = 1'b1;
      if (b_lock) begin
        state_d = LOCK_B;
        burst_d = (state_q != LOCK_B) ? CW'(1) : (cap ? burst_q : burst_q + 1'b1);
      end
    end
  end

  assign a_ack    = gnt_a;
  assign b_ack    = gnt_b;
  assign ram_wr   = (gnt_a & a_wr) | (gnt_b & b_wr);
  assign ram_addr = gnt_a ? a_addr  : (gnt_b ? b_addr  : hold_addr_q);
  assign ram_din  = gnt_a ? a_wdata : (gnt_b ? b_wdata : hold_din_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      burst_q     <= '0;
      hold_addr_q <= '0;
      hold_din_q  <= '0;
      vld_p1      <= 1'b0;
      own_b_p1    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      burst_q   <= burst_d;
      if (gnt_a || gnt_b) begin
        hold_addr_q <= ram_addr;
        hold_din_q  <= ram_din;
      end
      // ---- p1: read issued last cycle, BRAM data valid now ----
      vld_p1   <= (gnt_a & ~a_wr) | (gnt_b & ~b_wr);
      own_b_p1 <= gnt_b;
    end
  end

  assign a_rvalid = vld_p1 & ~own_b_p1;
  assign b_rvalid = vld_p1 &  own_b_p1;
  assign a_rdata  = a_rvalid ? ram_dout : '0;
  assign b_rdata  = b_rvalid ? ram_dout : '0;

  // Clients must keep an unacknowledged request stable until it is accepted.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (a_req && !a_ack) |=> (a_req && $stable(a_wr) && $stable(a_addr) && $stable(a_wdata)));
  b_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (b_req && !b_ack) |=> (b_req && $stable(b_wr) && $stable(b_addr) && $stable(b_wdata)));

endmodule

// File: tb/tb_bram_sp_arbiter.sv
module tb_bram_sp_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MB = 4;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_req, a_wr, a_lock, b_req, b_wr, b_lock;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_din, ram_dout;
  logic a_ack, b_ack, a_rvalid, b_rvalid, ram_wr;

  bram_sp_arbiter #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout));

  // Synchronous single-port BRAM behind the arbiter.
  logic init_mem;
  logic [DW-1:0] bram [2**AW];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 2**AW; k++) bram[k] <= '0;
    end else if (ram_wr) begin
      bram[ram_addr] <= ram_din;
    end
    ram_dout <= bram[ram_addr];
  end

  // Reference model state: who holds a lock, how many locked grants so far,
  // who won last, the pending read and the memory image.
  int lk, run, last, mw;
  bit pv;
  int po;
  logic [DW-1:0] pd, hdin;
  logic [AW-1:0] haddr;
  logic [DW-1:0] mem [2**AW];
  logic [4:0] e_ctl;
  logic [AW+DW-1:0] e_bus;
  logic [2*DW-1:0] e_rd;
  int checks = 0;
  int failures = 0;

  task automatic model_reset();
    lk = -1; run = 0; last = 1; mw = -1; pv = 0; po = 0; pd = '0;
    haddr = '0; hdin = '0;
  endtask

  // Expected outputs for the current cycle from the current inputs.
  task automatic model_eval();
    bit rq [2];
    logic cw;
    rq[0] = a_req; rq[1] = b_req;
    mw = -1;
    if (rst) begin
      if (lk >= 0 && rq[lk]) mw = (rq[1-lk] && run >= MB - 1) ? 1 - lk : lk;
      else if (rq[0] && rq[1]) mw = FIXED ? 0 : 1 - last;
      else if (rq[0]) mw = 0;
      else if (rq[1]) mw = 1;
    end
    cw = (mw == 0) ? a_wr : b_wr;
    e_ctl = {mw == 0, mw == 1, (mw >= 0) && cw, pv && po == 0, pv && po == 1};
    if (mw == 0)      e_bus = {a_addr, a_wdata};
    else if (mw == 1) e_bus = {b_addr, b_wdata};
    else              e_bus = {haddr, hdin};
    e_rd = {(pv && po == 0) ? pd : '0, (pv && po == 1) ? pd : '0};
  endtask

  // State update at the coming clock edge.
  task automatic model_commit();
    logic cw, cl;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    if (!rst) return;
    pv = 0;
    if (mw >= 0) begin
      cw = (mw == 0) ? a_wr : b_wr;
      cl = (mw == 0) ? a_lock : b_lock;
      ca = (mw == 0) ? a_addr : b_addr;
      cd = (mw == 0) ? a_wdata : b_wdata;
      if (cw) mem[ca] = cd;
      else begin pv = 1; po = mw; pd = mem[ca]; end
      haddr = ca; hdin = cd; last = mw;
      if (cl) begin run = (lk == mw) ? run + 1 : 1; lk = mw; end
      else begin lk = -1; run = 0; end
    end else begin
      lk = -1; run = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // A client keeps an unaccepted request; otherwise it may start a new one.
  task automatic drive_rand(input int c, input int pct, input int lpct, input int wpct);
    if (c == 0) begin
      if (!(a_req && mw != 0)) begin
        a_req = int'($urandom_range(99)) < pct;
        a_wr = int'($urandom_range(99)) < wpct;
        a_addr = AW'($urandom_range(2**AW - 1));
        a_wdata = $urandom;
      end
      a_lock = a_req && (int'($urandom_range(99)) < lpct);
    end else begin
      if (!(b_req && mw != 1)) begin
        b_req = int'($urandom_range(99)) < pct;
        b_wr = int'($urandom_range(99)) < wpct;
        b_addr = AW'($urandom_range(2**AW - 1));
        b_wdata = $urandom;
      end
      b_lock = b_req && (int'($urandom_range(99)) < lpct);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; init_mem = 1'b1;
    {a_req, a_wr, a_lock, b_req, b_wr, b_lock} = '0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    for (int k = 0; k < 2**AW; k++) mem[k] = '0;
    model_reset();
    @(posedge clk); #1; init_mem = 1'b0;
    sample();
    checks++;
    if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid, ram_addr, ram_din, a_rdata, b_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ctl=%b addr=%h din=%h exp all zero",
               {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, ram_addr, ram_din);
    end
    advance();
    rst = 1'b1; a_req = 1'b1; a_wr = 1'b0; a_addr = 4'd5;
    sample();
    checks++;
    if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== e_ctl) begin
      failures++; $display("FAIL reset_read_ack got=%b exp=%b", {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, e_ctl);
    end
    advance();
    rst = 1'b0; model_reset(); a_req = 1'b0;
    sample();
    checks++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0) begin
      failures++; $display("FAIL reset_midread rvalid=%b%b rdata=%h exp 0", a_rvalid, b_rvalid, a_rdata);
    end
    advance();
    rst = 1'b1;
    sample();
    checks++;
    if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== 5'b0) begin
      failures++; $display("FAIL reset_no_late_rvalid got=%b exp=00000", {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid});
    end
    advance();
    a_req = 1'b1; b_req = 1'b1; a_addr = 4'd1; b_addr = 4'd2;
    sample();
    checks++;
    if ({a_ack, b_ack} !== 2'b10) begin
      failures++; $display("FAIL reset_first_tie got ack=%b%b exp 10", a_ack, b_ack);
    end
    advance();
    a_req = 1'b0;
    sample();
    checks++;
    if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== e_ctl) begin
      failures++; $display("FAIL reset_b_after_tie got=%b exp=%b", {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, e_ctl);
    end
    advance();
    b_req = 1'b0;
  endtask

  task automatic test_single_read();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin a_req = 1'b1; a_wr = 1'b1; a_addr = 4'd3; a_wdata = 32'hDEADBEEF; end
        1: a_wr = 1'b0;
        default: a_req = 1'b0;
      endcase
      sample();
      checks++;
      if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== e_ctl) begin
        failures++; $display("FAIL single_ctl cyc=%0d got=%b exp=%b", i, {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, e_ctl);
      end
      checks++;
      if ({ram_addr, ram_din} !== e_bus) begin
        failures++; $display("FAIL single_bus cyc=%0d got=%h exp=%h", i, {ram_addr, ram_din}, e_bus);
      end
      checks++;
      if (i == 0 && {a_ack, ram_wr, ram_din} !== {2'b11, 32'hDEADBEEF}) begin
        failures++; $display("FAIL single_write ack=%b wr=%b din=%h exp 1 1 deadbeef", a_ack, ram_wr, ram_din);
      end
      if (i == 2 && {a_rvalid, b_rvalid, a_rdata} !== {2'b10, 32'hDEADBEEF}) begin
        failures++; $display("FAIL single_read rvalid=%b%b rdata=%h exp 10 deadbeef", a_rvalid, b_rvalid, a_rdata);
      end
      advance();
    end
  endtask

  task automatic test_contention();
    logic prev_a, prev_b;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(0, 100, 0, 0);
      drive_rand(1, 100, 0, 0);
      sample();
      checks++;
      if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== e_ctl) begin
        failures++; $display("FAIL cont_ctl cyc=%0d got=%b exp=%b", i, {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, e_ctl);
      end
      checks++;
      if ({a_rdata, b_rdata} !== e_rd) begin
        failures++; $display("FAIL cont_rdata cyc=%0d got=%h exp=%h", i, {a_rdata, b_rdata}, e_rd);
      end
      checks++;
`ifdef ARB_FIXED_PRIO_EN
      if ({a_ack, b_ack} !== 2'b10) begin
        failures++; $display("FAIL cont_fixed cyc=%0d ack=%b%b exp 10", i, a_ack, b_ack);
      end
`else
      if (i > 0 && ({a_ack, b_ack} !== {prev_b, prev_a})) begin
        failures++; $display("FAIL cont_alternate cyc=%0d ack=%b%b prev=%b%b", i, a_ack, b_ack, prev_a, prev_b);
      end
`endif
      checks++;
      if (i > 0 && ({a_rvalid, b_rvalid} !== {prev_a, prev_b})) begin
        failures++; $display("FAIL cont_latency cyc=%0d rvalid=%b%b exp=%b%b", i, a_rvalid, b_rvalid, prev_a, prev_b);
      end
      prev_a = a_ack; prev_b = b_ack;
      advance();
    end
    a_req = 1'b0;
    if (!(b_req && mw != 1)) b_addr = 4'd6;
    b_req = 1'b1;
    sample();
    checks++;
    if ({a_ack, b_ack} !== 2'b01) begin
      failures++; $display("FAIL cont_a_drops ack=%b%b exp 01", a_ack, b_ack);
    end
    advance();
    b_req = 1'b0;
  endtask

  task automatic test_burst();
    int a_run, max_run;
    a_run = 0; max_run = 0;
    for (int i = 0; i < 20; i++) begin
      drive_rand(0, (i < 16) ? 100 : 0, (i < 16) ? 100 : 0, 0);
      drive_rand(1, (i < 16) ? 100 : 0, 0, 0);
      sample();
      checks++;
      if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== e_ctl) begin
        failures++; $display("FAIL burst_ctl cyc=%0d got=%b exp=%b", i, {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, e_ctl);
      end
      checks++;
      if ({ram_addr, ram_din} !== e_bus) begin
        failures++; $display("FAIL burst_bus cyc=%0d got=%h exp=%h", i, {ram_addr, ram_din}, e_bus);
      end
      if (a_ack && b_req) a_run++;
      else if (b_ack) a_run = 0;
      if (a_run > max_run) max_run = a_run;
      advance();
    end
    checks++;
    if (max_run > MB || max_run == 0) begin
      failures++; $display("FAIL burst_cap longest A run while B waits=%0d exp 1..%0d", max_run, MB);
    end
  endtask

  task automatic test_hazard();
    logic first_a;
    first_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin a_req = 1'b0; b_req = 1'b1; b_wr = 1'b1; b_addr = 4'd7; b_wdata = 32'h5; end
        1: begin b_req = 1'b0; a_req = 1'b1; a_wr = 1'b0; a_addr = 4'd7; end
        2: a_req = 1'b0;
        3: begin
          a_req = 1'b1; a_wr = 1'b1; a_addr = 4'd9; a_wdata = 32'h111;
          b_req = 1'b1; b_wr = 1'b1; b_addr = 4'd9; b_wdata = 32'h222;
        end
        4: if (mw == 0) a_req = 1'b0; else b_req = 1'b0;
        5: begin b_req = 1'b0; a_req = 1'b1; a_wr = 1'b0; a_addr = 4'd9; end
        default: a_req = 1'b0;
      endcase
      sample();
      checks++;
      if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== e_ctl) begin
        failures++; $display("FAIL hazard_ctl cyc=%0d got=%b exp=%b", i, {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, e_ctl);
      end
      checks++;
      if ({ram_addr, ram_din, a_rdata, b_rdata} !== {e_bus, e_rd}) begin
        failures++; $display("FAIL hazard_data cyc=%0d got=%h exp=%h", i, {ram_addr, ram_din, a_rdata, b_rdata}, {e_bus, e_rd});
      end
      if (i == 3) first_a = a_ack;
      checks++;
      case (i)
        2: if ({a_rvalid, a_rdata} !== {1'b1, 32'h5}) begin
             failures++; $display("FAIL hazard_wr_rd rvalid=%b rdata=%h exp 1 00000005", a_rvalid, a_rdata);
           end
        3: if ({a_ack ^ b_ack, ram_wr, ram_din} !== {2'b11, (a_ack ? 32'h111 : 32'h222)}) begin
             failures++; $display("FAIL hazard_same_cycle ack=%b%b wr=%b din=%h", a_ack, b_ack, ram_wr, ram_din);
           end
        6: if (a_rdata !== (first_a ? 32'h222 : 32'h111)) begin
             failures++; $display("FAIL hazard_final rdata=%h exp=%h", a_rdata, first_a ? 32'h222 : 32'h111);
           end
        default: if ({a_ack & b_ack} !== 1'b0) begin
             failures++; $display("FAIL hazard_double_ack cyc=%0d", i);
           end
      endcase
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive_rand(0, (i < 490) ? 60 : 0, 40, 50);
      drive_rand(1, (i < 490) ? 60 : 0, 40, 50);
      sample();
      checks++;
      if ({a_ack, b_ack, ram_wr, a_rvalid, b_rvalid} !== e_ctl) begin
        failures++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", i, {a_ack, b_ack, ram_wr, a_rvalid, b_rvalid}, e_ctl);
      end
      checks++;
      if ({ram_addr, ram_din} !== e_bus) begin
        failures++; $display("FAIL rand_bus cyc=%0d got=%h exp=%h", i, {ram_addr, ram_din}, e_bus);
      end
      checks++;
      if ({a_rdata, b_rdata} !== e_rd) begin
        failures++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", i, {a_rdata, b_rdata}, e_rd);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_burst();
    test_hazard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
